// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory arbiter and load extension.
package dmem_pkg;

   localparam logic [1:0] TYPE_WORD    = 2'd0;
   localparam logic [1:0] TYPE_HALF    = 2'd1;
   localparam logic [1:0] TYPE_BYTE    = 2'd2;
   localparam logic [1:0] TYPE_ILLEGAL = 2'd3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Latched command; the address is kept separately because its width is a parameter.
   typedef struct packed {
      logic        port;
      logic        we;
      logic [31:0] wdata;
      logic [1:0]  dtype;
      logic        uns;
      logic        err;
   } cmd_t;

   function automatic logic misaligned(input logic [1:0] dtype, input logic [1:0] addr_lo);
      return ((dtype == TYPE_WORD) && (addr_lo != 2'b00)) ||
             ((dtype == TYPE_HALF) && addr_lo[0]);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
// dtype: 0 word, 1 half, 2 byte, 3 illegal. is_unsigned selects zero-extension of loads.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 10
) ();
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [1:0]        dtype;
   logic              is_unsigned;
   logic              gnt;
   logic              done;
   logic [31:0]       rdata;
   logic              err;

   modport master (
      output req, we, addr, wdata, dtype, is_unsigned,
      input  gnt, done, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata, dtype, is_unsigned,
      output gnt, done, rdata, err
   );
endinterface

// File: rtl/load_extend.sv
// Extracts the low byte/half of right-aligned memory read data and extends it.
// Also used by the CPU writeback path.
module load_extend
   import dmem_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  dtype,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   // Select width and fill bits for the extension.
   always_comb begin
      result = 32'd0;
      case (dtype)
         TYPE_WORD: result = data;
         TYPE_HALF: result = {{16{~is_unsigned & data[15]}}, data[15:0]};
         TYPE_BYTE: result = {{24{~is_unsigned & data[7]}}, data[7:0]};
         default:   result = 32'd0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the synchronous 1 KiB data memory.
// Port 0 is the CPU load/store unit, port 1 the debug/loader master.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | no access in flight; arbitrate on any req
//   ST_ACCESS | memory strobes driven from cmd for exactly one cycle
//   ST_RESP   | done/err/rdata for cmd.port; arbitrate for the next access
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter bit RR_EN       = 1'b1,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   dmem_arbiter_if.slave     p0,
   dmem_arbiter_if.slave     p1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [1:0]        mem_type,
   input  logic [31:0]       mem_rdata
);

   logic [1:0]        state;
   cmd_t              cmd;
   logic [ADDR_W-1:0] cmd_addr;
   logic [1:0]        gnt_q;
   logic [1:0]        done_q;
   logic              last_port;

   logic              arb_point;
   logic              any_req;
   logic              win;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [1:0]        sel_dtype;
   logic              sel_uns;
   logic              sel_err;
   logic              in_access;
   logic              rd_ok;
   logic [31:0]       ext_data;

   assign arb_point = (state == ST_IDLE) || (state == ST_RESP);
   assign any_req   = p0.req | p1.req;

   // Winner select: on a tie, round-robin favours the port not granted last.
   always_comb begin
      win = p1.req;
      if (p0.req && p1.req) begin
         win = RR_EN ? ~last_port : 1'b0;
      end
   end

   // Mux the winning port's fields and classify the access.
   always_comb begin
      sel_we    = win ? p1.we          : p0.we;
      sel_addr  = win ? p1.addr        : p0.addr;
      sel_wdata = win ? p1.wdata       : p0.wdata;
      sel_dtype = win ? p1.dtype       : p0.dtype;
      sel_uns   = win ? p1.is_unsigned : p0.is_unsigned;
      sel_err   = (sel_dtype == TYPE_ILLEGAL) ||
                  (ALIGN_CHECK && misaligned(sel_dtype, sel_addr[1:0]));
   end

   // Sequencer, command register, and registered gnt/done pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cmd       <= '0;
         cmd_addr  <= '0;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         last_port <= 1'b1;
      end else begin
         gnt_q  <= 2'b00;
         done_q <= 2'b00;
         case (state)
            ST_IDLE, ST_RESP: begin
               if (any_req) begin
                  state       <= ST_ACCESS;
                  cmd.port    <= win;
                  cmd.we      <= sel_we;
                  cmd.wdata   <= sel_wdata;
                  cmd.dtype   <= sel_dtype;
                  cmd.uns     <= sel_uns;
                  cmd.err     <= sel_err;
                  cmd_addr    <= sel_addr;
                  gnt_q[win]  <= 1'b1;
                  last_port   <= win;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               state           <= ST_RESP;
               done_q[cmd.port] <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The strobes see rst directly so a reset landing in ACCESS cannot commit a store.
   assign in_access = (state == ST_ACCESS) && !rst;
   assign mem_read  = in_access && !cmd.we && !cmd.err;
   assign mem_write = in_access &&  cmd.we && !cmd.err;
   assign mem_addr  = cmd_addr;
   assign mem_wdata = cmd.wdata;
   assign mem_type  = cmd.dtype;

   load_extend u_load_extend (
      .data        (mem_rdata),
      .dtype       (cmd.dtype),
      .is_unsigned (cmd.uns),
      .result      (ext_data)
   );

   assign rd_ok = !cmd.we && !cmd.err;

   assign p0.gnt   = gnt_q[0];
   assign p1.gnt   = gnt_q[1];
   assign p0.done  = done_q[0];
   assign p1.done  = done_q[1];
   assign p0.err   = done_q[0] && cmd.err;
   assign p1.err   = done_q[1] && cmd.err;
   assign p0.rdata = (done_q[0] && rd_ok) ? ext_data : 32'd0;
   assign p1.rdata = (done_q[1] && rd_ok) ? ext_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a little-endian byte memory model.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_clr = 1'b1;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(10)) p0_if ();
   dmem_arbiter_if #(.ADDR_W(10)) p1_if ();
   dmem_arbiter_if #(.ADDR_W(10)) q0_if ();
   dmem_arbiter_if #(.ADDR_W(10)) q1_if ();

   logic [9:0]  mem_addr, fp_mem_addr;
   logic [31:0] mem_wdata, fp_mem_wdata;
   logic        mem_read, mem_write, fp_mem_read, fp_mem_write;
   logic [1:0]  mem_type, fp_mem_type;
   logic [31:0] mem_rdata = 32'd0;
   logic [31:0] fp_mem_rdata = 32'd0;

   dmem_arbiter #(.ADDR_W(10), .RR_EN(1'b1), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_type(mem_type), .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.ADDR_W(10), .RR_EN(1'b0), .ALIGN_CHECK(1'b1)) dut_fp (
      .clk(clk), .rst(rst), .p0(q0_if), .p1(q1_if),
      .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_read(fp_mem_read),
      .mem_write(fp_mem_write), .mem_type(fp_mem_type), .mem_rdata(fp_mem_rdata)
   );

   logic [7:0] mem [0:1023];
   int wr_cnt = 0;
   int rd_cnt = 0;
   int n_chk = 0;
   int n_err = 0;

   // Synchronous memory: right-aligned read data, little-endian byte lanes, wrap at top.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else begin
         if (mem_read)
            mem_rdata <= {mem[mem_addr + 10'd3], mem[mem_addr + 10'd2],
                          mem[mem_addr + 10'd1], mem[mem_addr]};
         if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_type != TYPE_BYTE) mem[mem_addr + 10'd1] <= mem_wdata[15:8];
            if (mem_type == TYPE_WORD) begin
               mem[mem_addr + 10'd2] <= mem_wdata[23:16];
               mem[mem_addr + 10'd3] <= mem_wdata[31:24];
            end
         end
      end
   end

   // Count strobe cycles seen by the memory.
   always @(posedge clk) begin
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (mem_read)  rd_cnt <= rd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input int port, input logic req, input logic we, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [1:0] dtype, input logic uns);
      if (port == 0) begin
         p0_if.req = req; p0_if.we = we; p0_if.addr = addr;
         p0_if.wdata = wdata; p0_if.dtype = dtype; p0_if.is_unsigned = uns;
      end else begin
         p1_if.req = req; p1_if.we = we; p1_if.addr = addr;
         p1_if.wdata = wdata; p1_if.dtype = dtype; p1_if.is_unsigned = uns;
      end
   endtask

   // One access, started at a negedge; gnt checked one cycle later, done two cycles later.
   task automatic xfer(input string tag, input int port, input logic we, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic [1:0] dtype, input logic uns,
                       input logic exp_err, input logic [31:0] exp_rdata);
      int wr0, rd0;
      logic [1:0] exp_pulse;
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      exp_pulse = (port == 0) ? 2'b01 : 2'b10;
      drive(port, 1'b1, we, addr, wdata, dtype, uns);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".gnt"}, {30'd0, p1_if.gnt, p0_if.gnt}, {30'd0, exp_pulse});
      chk({tag, ".strobe"}, {30'd0, mem_read, mem_write},
          {30'd0, !we && !exp_err, we && !exp_err});
      drive(port, 1'b0, 1'b0, 10'd0, 32'd0, TYPE_WORD, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".done"}, {30'd0, p1_if.done, p0_if.done}, {30'd0, exp_pulse});
      chk({tag, ".err"}, {31'd0, (port == 0) ? p0_if.err : p1_if.err}, {31'd0, exp_err});
      chk({tag, ".rdata"}, (port == 0) ? p0_if.rdata : p1_if.rdata, exp_rdata);
      chk({tag, ".nstrb"}, wr_cnt - wr0 + rd_cnt - rd0, {31'd0, !exp_err});
   endtask

   logic [3:0] rr_exp [8];
   logic [1:0] fp_exp [7];

   initial begin
      rr_exp = '{4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0100, 4'b0001};
      fp_exp = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
      drive(0, 1'b0, 1'b0, 10'd0, 32'd0, TYPE_WORD, 1'b0);
      drive(1, 1'b0, 1'b0, 10'd0, 32'd0, TYPE_WORD, 1'b0);
      q0_if.req = 1'b0; q0_if.we = 1'b0; q0_if.addr = 10'd0;
      q0_if.wdata = 32'd0; q0_if.dtype = TYPE_BYTE; q0_if.is_unsigned = 1'b0;
      q1_if.req = 1'b0; q1_if.we = 1'b0; q1_if.addr = 10'd4;
      q1_if.wdata = 32'd0; q1_if.dtype = TYPE_BYTE; q1_if.is_unsigned = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.ctl", {24'd0, p0_if.gnt, p0_if.done, p0_if.err, p1_if.gnt, p1_if.done,
                      p1_if.err, mem_read, mem_write}, 32'd0);
      chk("rst.bus", {20'd0, mem_addr, mem_type}, 32'd0);
      chk("rst.rdata", p0_if.rdata | p1_if.rdata | mem_wdata, 32'd0);
      chk("rst.state", {30'd0, dut.state}, {30'd0, ST_IDLE});
      rst = 1'b0;
      mem_clr = 1'b0;
      @(negedge clk);

      xfer("st_w",    0, 1'b1, 10'h010, 32'hDEADBEEF, TYPE_WORD, 1'b0, 1'b0, 32'h0);
      xfer("ld_w",    0, 1'b0, 10'h010, 32'h0,        TYPE_WORD, 1'b0, 1'b0, 32'hDEADBEEF);
      xfer("ld_bs",   0, 1'b0, 10'h013, 32'h0,        TYPE_BYTE, 1'b0, 1'b0, 32'hFFFFFFDE);
      xfer("ld_bu",   0, 1'b0, 10'h013, 32'h0,        TYPE_BYTE, 1'b1, 1'b0, 32'h000000DE);
      xfer("ld_hs",   0, 1'b0, 10'h012, 32'h0,        TYPE_HALF, 1'b0, 1'b0, 32'hFFFFDEAD);
      xfer("ld_hmis", 0, 1'b0, 10'h011, 32'h0,        TYPE_HALF, 1'b0, 1'b1, 32'h0);
      xfer("st_wmis", 0, 1'b1, 10'h012, 32'h11111111, TYPE_WORD, 1'b0, 1'b1, 32'h0);
      xfer("ld_wchk", 0, 1'b0, 10'h010, 32'h0,        TYPE_WORD, 1'b0, 1'b0, 32'hDEADBEEF);
      xfer("st_b",    0, 1'b1, 10'h000, 32'h00000080, TYPE_BYTE, 1'b0, 1'b0, 32'h0);
      xfer("p1_ill",  1, 1'b0, 10'h000, 32'h0,        TYPE_ILLEGAL, 1'b0, 1'b1, 32'h0);
      xfer("p1_ldb",  1, 1'b0, 10'h000, 32'h0,        TYPE_BYTE, 1'b0, 1'b0, 32'hFFFFFF80);

      // Round-robin: last grant went to port 1, so port 0 leads.
      drive(0, 1'b1, 1'b0, 10'h010, 32'h0, TYPE_WORD, 1'b0);
      drive(1, 1'b1, 1'b0, 10'h013, 32'h0, TYPE_BYTE, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("rr.c%0d", i + 1),
             {28'd0, p0_if.gnt, p1_if.gnt, p0_if.done, p1_if.done}, {28'd0, rr_exp[i]});
         chk($sformatf("rr.rd%0d", i + 1), p0_if.rdata | p1_if.rdata,
             rr_exp[i][1] ? 32'hDEADBEEF : (rr_exp[i][0] ? 32'h000000DE : 32'h0));
         if (i == 6) begin
            drive(0, 1'b0, 1'b0, 10'd0, 32'd0, TYPE_WORD, 1'b0);
            drive(1, 1'b0, 1'b0, 10'd0, 32'd0, TYPE_WORD, 1'b0);
         end
      end

      // Reset landing in the ACCESS cycle of a store.
      xfer("st_pre", 0, 1'b1, 10'h020, 32'hCAFEF00D, TYPE_WORD, 1'b0, 1'b0, 32'h0);
      begin
         int wr0;
         wr0 = wr_cnt;
         drive(0, 1'b1, 1'b1, 10'h020, 32'h12345678, TYPE_WORD, 1'b0);
         @(posedge clk);
         @(negedge clk);
         chk("rmid.gnt", {31'd0, p0_if.gnt}, 32'd1);
         rst = 1'b1;
         drive(0, 1'b0, 1'b0, 10'd0, 32'd0, TYPE_WORD, 1'b0);
         #1;
         chk("rmid.wgate", {31'd0, mem_write}, 32'd0);
         @(posedge clk);
         @(negedge clk);
         chk("rmid.ctl", {24'd0, p0_if.gnt, p0_if.done, p0_if.err, p1_if.gnt, p1_if.done,
                          p1_if.err, mem_read, mem_write}, 32'd0);
         chk("rmid.bus", {20'd0, mem_addr, mem_type}, 32'd0);
         chk("rmid.data", p0_if.rdata | mem_wdata, 32'd0);
         chk("rmid.state", {30'd0, dut.state}, {30'd0, ST_IDLE});
         chk("rmid.nowr", wr_cnt - wr0, 32'd0);
         rst = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("rmid.nodone", {30'd0, p0_if.done, p1_if.done}, 32'd0);
      end
      xfer("ld_post", 0, 1'b0, 10'h020, 32'h0, TYPE_WORD, 1'b0, 1'b0, 32'hCAFEF00D);

      // Fixed priority: port 0 wins while it requests, then port 1 gets through.
      q0_if.req = 1'b1;
      q1_if.req = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("fp.c%0d", i + 1), {30'd0, q0_if.gnt, q1_if.gnt}, {30'd0, fp_exp[i]});
         if (i == 4) q0_if.req = 1'b0;
         if (i == 6) q1_if.req = 1'b0;
      end
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
